// File: rtl/i2s_pcm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pcm_fifo
// Description : I2S slot-word to PCM sample stage with channel filter, FWFT
//               FIFO, threshold IRQ and sticky overflow. Optional per-channel
//               boxcar decimator enabled by defining I2S_PCM_DECIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_pcm_fifo #(
    parameter int SAMPLE_W   = 24,
    parameter int DEPTH_LOG2 = 4,
    parameter int DECIM_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic [1:0]            chan_sel_i,
    input  logic                  in_valid_i,
    input  logic [31:0]           in_data_i,
    input  logic                  in_ws_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_data_o,
    output logic                  out_chan_o,
    output logic [DEPTH_LOG2:0]   level_o,
    input  logic [DEPTH_LOG2:0]   thresh_i,
    output logic                  thresh_irq_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    localparam int               DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [31:0] w_sample;
    logic        w_accept;
    logic        w_push;
    logic [31:0] w_push_data;
    logic        w_push_chan;

    // Arithmetic shift drops the pad bits below the sample and sign-extends.
    assign w_sample    = 32'($signed(in_data_i) >>> (32 - SAMPLE_W));
    assign w_accept    = en_i & in_valid_i & (chan_sel_i[1] | (in_ws_i == chan_sel_i[0]));
    assign w_push_chan = in_ws_i;

`ifdef I2S_PCM_DECIM_EN
    localparam int ACC_W = 32 + DECIM_LOG2;

    logic [ACC_W-1:0]      acc_q [2];
    logic [DECIM_LOG2-1:0] cnt_q [2];
    logic [ACC_W-1:0]      w_sum;

    assign w_sum       = acc_q[in_ws_i] + ACC_W'($signed(w_sample));
    assign w_push      = w_accept & (cnt_q[in_ws_i] == '1);
    // Taking the bit window above DECIM_LOG2 is the floor division of the sum.
    assign w_push_data = w_sum[DECIM_LOG2 +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else if (flush_i) begin
            for (int c = 0; c < 2; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else if (w_accept) begin
            if (cnt_q[in_ws_i] == '1) begin
                acc_q[in_ws_i] <= '0;
                cnt_q[in_ws_i] <= '0;
            end else begin
                acc_q[in_ws_i] <= w_sum;
                cnt_q[in_ws_i] <= cnt_q[in_ws_i] + 1'b1;
            end
        end
    end
`else
    logic [31:0] w_unused_decim;

    assign w_push         = w_accept;
    assign w_push_data    = w_sample;
    assign w_unused_decim = DECIM_LOG2;
`endif

    logic [32:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  w_empty, w_full, w_pop, w_wr, w_drop;
    logic [32:0]           w_head;

    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == LVL_FULL);
    assign w_pop   = ~w_empty & out_ready_i & ~flush_i;
    assign w_wr    = w_push & ~flush_i & (~w_full | w_pop);
    assign w_drop  = w_push & ~flush_i & w_full & ~w_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        // A drop in the same cycle as a clear request leaves the flag set.
        if (w_drop)         ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= {w_push_chan, w_push_data};
    end

    assign w_head       = w_empty ? 33'd0 : mem_q[rd_ptr_q];
    assign out_valid_o  = ~w_empty;
    assign out_chan_o   = w_head[32];
    assign out_data_o   = w_head[31:0];
    assign level_o      = level_q;
    assign ovf_o        = ovf_q;
    assign thresh_irq_o = (thresh_i != '0) && (level_q >= thresh_i);

endmodule
`default_nettype wire

// File: tb/tb_i2s_pcm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_pcm_fifo
// Description : Directed vector table plus hand-written multi-cycle sequences
//               for i2s_pcm_fifo (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_pcm_fifo;

    logic        clk = 1'b0;
    logic        rst, en, flush, in_valid, in_ws, out_ready, ovf_clr;
    logic [1:0]  chan_sel;
    logic [31:0] in_data;
    logic [4:0]  thresh;
    logic        out_valid, out_chan, thresh_irq, ovf;
    logic [31:0] out_data;
    logic [4:0]  level;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2s_pcm_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .flush_i      (flush),
        .chan_sel_i   (chan_sel),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ws_i      (in_ws),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_chan_o   (out_chan),
        .level_o      (level),
        .thresh_i     (thresh),
        .thresh_irq_o (thresh_irq),
        .ovf_o        (ovf),
        .ovf_clr_i    (ovf_clr)
    );

    typedef struct {
        logic        en;
        logic [1:0]  cs;
        logic        iv;
        logic [31:0] d;
        logic        ws;
        logic        rdy;
        logic [4:0]  th;
        logic        ev;
        logic [31:0] ed;
        logic        ec;
        logic [4:0]  el;
        logic        eirq;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic [1:0] cs, logic iv, logic [31:0] d, logic ws,
                                logic rdy, logic [4:0] th, logic ev, logic [31:0] ed,
                                logic ec, logic [4:0] el, logic eirq, logic eovf);
        vec_t v;
        v.en = e; v.cs = cs; v.iv = iv; v.d = d; v.ws = ws; v.rdy = rdy; v.th = th;
        v.ev = ev; v.ed = ed; v.ec = ec; v.el = el; v.eirq = eirq; v.eovf = eovf;
        return v;
    endfunction

    // Slot word carrying a small signed sample value in the top 24 bits.
    function automatic logic [31:0] s2d(int v);
        return 32'(v) << 8;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] d, logic ws);
        in_valid = 1'b1;
        in_data  = d;
        in_ws    = ws;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ws = 1'b0;
        out_ready = 1'b0; ovf_clr = 1'b0; chan_sel = 2'b10; in_data = '0; thresh = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset.valid", {31'd0, out_valid}, 32'd0);
        chk("reset.level", {27'd0, level}, 32'd0);
        chk("reset.ovf",   {31'd0, ovf}, 32'd0);
        chk("reset.irq",   {31'd0, thresh_irq}, 32'd0);
        chk("reset.data",  out_data, 32'd0);

`ifdef I2S_PCM_DECIM_EN
        // Left 1,2,3,6 with filtered right traffic between them -> average 3.
        chan_sel = 2'b00;
        push(s2d(1), 1'b0); push(s2d(9), 1'b1);
        push(s2d(2), 1'b0); push(s2d(9), 1'b1);
        push(s2d(3), 1'b0); push(s2d(9), 1'b1);
        chk("dec.partial.level", {27'd0, level}, 32'd0);
        push(s2d(6), 1'b0);
        chk("dec.avg3.level", {27'd0, level}, 32'd1);
        chk("dec.avg3.data", out_data, 32'd3);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chan_sel = 2'b10;
        for (int k = 0; k < 4; k++) begin
            push(s2d(k == 3 ? -2 : -1), 1'b0);
            push(s2d(4), 1'b1);
        end
        chk("dec.both.level", {27'd0, level}, 32'd2);
        chk("dec.neg.data", out_data, 32'hFFFF_FFFE);
        chk("dec.neg.chan", {31'd0, out_chan}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("dec.right.data", out_data, 32'd4);
        chk("dec.right.chan", {31'd0, out_chan}, 32'd1);
`else
        vecs.push_back(mk(1, 2, 1, 32'hFFFFFF00, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 1, 32'h12345600, 1, 0, 0, 1, 32'hFFFFFFFF, 0, 2, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h0,        0, 1, 0, 1, 32'h00123456, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 32'h11111100, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 1, 32'h800000FF, 1, 0, 0, 1, 32'hFF800000, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h7FFFFF00, 0, 0, 0, 1, 32'hFF800000, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h7FFFFF00, 1, 0, 2, 1, 32'hFF800000, 1, 2, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 1, 2, 1, 32'h007FFFFF, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 1, 2, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 1, 32'h00000A00, 0, 1, 0, 1, 32'h0000000A, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        // Left-only filter: alternating ws, only even strobes land.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 1, s2d(i + 1), 1'(i % 2), 0, 0, 1, 32'd1, 0,
                              5'(i / 2 + 1), 0, 0));
        for (int j = 0; j < 4; j++)
            vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, 1'(j < 3),
                              (j < 3) ? 32'(2 * j + 3) : 32'd0, 0, 5'(3 - j), 0, 0));

        foreach (vecs[i]) begin
            en = vecs[i].en; chan_sel = vecs[i].cs; in_valid = vecs[i].iv; in_data = vecs[i].d;
            in_ws = vecs[i].ws; out_ready = vecs[i].rdy; thresh = vecs[i].th;
            tick();
            chk($sformatf("vec%0d.valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d.data", i), out_data, vecs[i].ed);
            chk($sformatf("vec%0d.chan", i), {31'd0, out_chan}, {31'd0, vecs[i].ec});
            chk($sformatf("vec%0d.level", i), {27'd0, level}, {27'd0, vecs[i].el});
            chk($sformatf("vec%0d.irq", i), {31'd0, thresh_irq}, {31'd0, vecs[i].eirq});
            chk($sformatf("vec%0d.ovf", i), {31'd0, ovf}, {31'd0, vecs[i].eovf});
        end
        en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; thresh = '0; chan_sel = 2'b10;

        // Fill past full: 17th sample dropped and flagged.
        for (int k = 0; k < 17; k++) begin
            push(s2d(k + 1), 1'(k % 2));
            if (k == 15) begin
                chk("full.level16", {27'd0, level}, 32'd16);
                chk("full.ovf0", {31'd0, ovf}, 32'd0);
            end
        end
        chk("ovf.level", {27'd0, level}, 32'd16);
        chk("ovf.set", {31'd0, ovf}, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d.data", k), out_data, 32'(k + 1));
            chk($sformatf("drain%0d.chan", k), {31'd0, out_chan}, 32'(k % 2));
            tick();
        end
        out_ready = 1'b0;
        chk("drain.empty", {31'd0, out_valid}, 32'd0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf.clr", {31'd0, ovf}, 32'd0);

        for (int k = 0; k < 16; k++) push(s2d(100 + k), 1'b0);
        out_ready = 1'b1;
        push(s2d(200), 1'b1);
        out_ready = 1'b0;
        chk("fullpp.level", {27'd0, level}, 32'd16);
        chk("fullpp.ovf", {31'd0, ovf}, 32'd0);
        chk("fullpp.head", out_data, 32'd101);

        ovf_clr = 1'b1;
        push(s2d(300), 1'b0);
        ovf_clr = 1'b0;
        chk("ovf.beats_clr", {31'd0, ovf}, 32'd1);
        flush = 1'b1;
        push(s2d(400), 1'b0);
        flush = 1'b0;
        chk("flush.level", {27'd0, level}, 32'd0);
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        chk("flush.keeps_ovf", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // Threshold IRQ edges.
        thresh = 5'd4;
        for (int k = 0; k < 4; k++) begin
            push(s2d(k), 1'b0);
            chk($sformatf("irq.rise%0d", k), {31'd0, thresh_irq}, 32'(k == 3));
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("irq.fall.level", {27'd0, level}, 32'd3);
        chk("irq.fall", {31'd0, thresh_irq}, 32'd0);
        push(s2d(7), 1'b0);
        push(s2d(8), 1'b0);
        chk("irq.level5", {31'd0, thresh_irq}, 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("irq.flush.level", {27'd0, level}, 32'd0);
        chk("irq.flush", {31'd0, thresh_irq}, 32'd0);
        thresh = 5'd0;
        for (int k = 0; k < 16; k++) push(s2d(k), 1'b1);
        chk("irq.disabled", {31'd0, thresh_irq}, 32'd0);
        thresh = 5'd16;
        #1;
        chk("irq.at_full", {31'd0, thresh_irq}, 32'd1);

        // Asynchronous reset mid-stream.
        push(s2d(500), 1'b0);
        chk("pre_rst.ovf", {31'd0, ovf}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.level", {27'd0, level}, 32'd0);
        chk("rst.ovf", {31'd0, ovf}, 32'd0);
        chk("rst.irq", {31'd0, thresh_irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(s2d(85), 1'b1);
        chk("post_rst.level", {27'd0, level}, 32'd1);
        chk("post_rst.data", out_data, 32'd85);
        chk("post_rst.chan", {31'd0, out_chan}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
